// File: rtl/uart_pkg.sv
// Shared types and oversampling constants for the UART byte receiver.
// UART_RX_PARITY_EN adds the PARITY state for one even-parity bit.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE   = 16;
  localparam int SAMPLE_FIRST = 5;
  localparam int SAMPLE_LAST  = 11;
  localparam int DECIDE_TICK  = 12;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, realigned by restart.
// Used by uart_byte_rx; no configuration macros apply here.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_baud_tick: DIV must be at least 2");
  end

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (restart || cnt_reg == W'(DIV - 1)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == W'(DIV - 1));

endmodule

// File: rtl/uart_byte_rx.sv
// 16x oversampling UART byte receiver with 7-sample majority vote per bit.
// Define UART_RX_PARITY_EN for an even-parity bit after the data byte (default strict 8N1).
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err
);

  localparam int BAUD_DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int SYNC_STAGES = 2;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_reg;
  logic                   rx_s;
  logic                   fall;
  logic                   tick;
  logic                   restart;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      assign sync_d[gi] = uart_rx;
    end else begin : g_next
      assign sync_d[gi] = sync_reg[gi-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '1;
      prev_reg <= 1'b1;
    end else begin
      sync_reg <= sync_d;
      prev_reg <= rx_s;
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];
  assign fall = prev_reg & ~rx_s;

  rx_state_t  state_reg, state_next;
  logic [3:0] tick_idx_reg, tick_idx_next;
  logic [2:0] bit_idx_reg, bit_idx_next;
  logic [2:0] ones_reg, ones_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       done_reg, done_next;
  logic       err_reg, err_next;
  logic       bit_val;
  logic       decide;
  logic       bit_end;
  logic       in_window;
`ifdef UART_RX_PARITY_EN
  logic       parity_reg, parity_next;
`endif

  assign restart = (state_reg == IDLE) && fall;

  uart_baud_tick #(.DIV(BAUD_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  assign bit_val   = (ones_reg >= 3'd4);
  assign decide    = tick && (tick_idx_reg == 4'(DECIDE_TICK));
  assign bit_end   = tick && (tick_idx_reg == 4'(OVERSAMPLE - 1));
  assign in_window = (tick_idx_reg >= 4'(SAMPLE_FIRST)) && (tick_idx_reg <= 4'(SAMPLE_LAST));

  always_comb begin
    state_next    = state_reg;
    tick_idx_next = tick_idx_reg;
    bit_idx_next  = bit_idx_reg;
    ones_next     = ones_reg;
    shift_next    = shift_reg;
    rx_data_next  = rx_data_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_next   = parity_reg;
`endif

    // The tick index free-runs across bit boundaries so every bit keeps frame-relative timing.
    if (state_reg != IDLE && tick) begin
      tick_idx_next = tick_idx_reg + 4'd1;
      if (in_window) ones_next = ones_reg + {2'b00, rx_s};
      if (decide)    ones_next = 3'd0;
    end

    case (state_reg)
      IDLE: begin
        if (fall) begin
          state_next    = START;
          tick_idx_next = 4'd0;
          bit_idx_next  = 3'd0;
          ones_next     = 3'd0;
`ifdef UART_RX_PARITY_EN
          parity_next   = 1'b0;
`endif
        end
      end
      START: begin
        if (decide && bit_val) state_next = IDLE;
        else if (bit_end)      state_next = DATA;
      end
      DATA: begin
        if (decide) begin
          shift_next = {bit_val, shift_reg[7:1]};
`ifdef UART_RX_PARITY_EN
          parity_next = parity_reg ^ bit_val;
`endif
        end
        if (bit_end) begin
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (decide)  parity_next = parity_reg ^ bit_val;
        if (bit_end) state_next  = STOP;
      end
`endif
      STOP: begin
        // Decide mid stop bit so a start bit with zero idle time is still seen as an edge.
        if (decide) begin
          state_next = IDLE;
`ifdef UART_RX_PARITY_EN
          if (bit_val && !parity_reg) begin
`else
          if (bit_val) begin
`endif
            rx_data_next = shift_reg;
            done_next    = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      tick_idx_reg <= 4'd0;
      bit_idx_reg  <= 3'd0;
      ones_reg     <= 3'd0;
      shift_reg    <= 8'h00;
      rx_data_reg  <= 8'h00;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      tick_idx_reg <= tick_idx_next;
      bit_idx_reg  <= bit_idx_next;
      ones_reg     <= ones_next;
      shift_reg    <= shift_next;
      rx_data_reg  <= rx_data_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
`ifdef UART_RX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_done   = done_reg;
  assign frame_err = err_reg;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: table vectors, corner sequences and random frames vs a frame-level model.
// Runs at BAUD_DIV = 4 to keep run length short; all timing is expressed in BAUD_DIV units.
`timescale 1ns/1ps
module tb_uart_byte_rx;

  localparam int  CLK_FREQ = 50_000_000;
  localparam int  BAUD     = 769_231;
  localparam int  BAUD_DIV = CLK_FREQ / (BAUD * 16);
  localparam real BIT_CLKS = real'(CLK_FREQ) / real'(BAUD);
`ifdef UART_RX_PARITY_EN
  localparam int NBITS        = 11;
  localparam int DECIDE_TICKS = 173;
`else
  localparam int NBITS        = 10;
  localparam int DECIDE_TICKS = 157;
`endif
  // Two synchronizer clocks to t0, then the decision tick, then the output register.
  localparam int LATENCY = 2 + DECIDE_TICKS * BAUD_DIV + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } evt_t;

  typedef struct {
    logic       done;
    logic       err;
    logic [7:0] data;
    int         cyc;
  } obs_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         par_ok;
    real        err_pct;
    bit         exp_err;
    logic [7:0] exp_rx;
  } vec_t;

  evt_t       exp_q[$];
  obs_t       obs_q[$];
  logic [7:0] model_last = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;

  always @(negedge clk) begin
    if (rx_done || frame_err) obs_q.push_back('{rx_done, frame_err, rx_data, cyc});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_frame(input logic [10:0] bits, input real err_pct, input int rst_bit,
                             output int start_c);
    real per;
    int  n;
    per = BIT_CLKS / (1.0 + err_pct / 100.0);
    start_c = cyc;
    for (int i = 0; i < NBITS; i++) begin
      uart_rx = bits[i];
      n = $rtoi((i + 1) * per + 0.5) - $rtoi(i * per + 0.5);
      if (i == rst_bit) begin
        repeat (n / 2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_done", rx_done, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        repeat (n - n / 2) @(posedge clk);
        #1;
      end else begin
        repeat (n) @(posedge clk);
        #1;
      end
    end
    uart_rx = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input bit stop_bit, input bit par_ok,
                      input real err_pct, input int gap, output int start_c);
    logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop_bit, (^d) ^ ~par_ok, d, 1'b0};
`else
    bits = {1'b1, stop_bit, d, 1'b0};
`endif
    exp_q.push_back('{err: !(stop_bit && par_ok), data: d});
    drive_frame(bits, err_pct, -1, start_c);
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  // Match every expected frame outcome against the observed pulses in order.
  task automatic drain();
    evt_t e;
    obs_t o;
    repeat (20) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        check("missing_pulse", 0, 1);
      end else begin
        o = obs_q.pop_front();
        check("done_err_exclusive", o.done & o.err, 1'b0);
        check("pulse_is_err", o.err, e.err);
        check("pulse_is_done", o.done, !e.err);
        if (!e.err) begin
          check("rx_data_good", o.data, e.data);
          model_last = e.data;
        end else begin
          check("rx_data_held", o.data, model_last);
        end
      end
    end
    check("extra_pulses", obs_q.size(), 0);
    obs_q.delete();
  endtask

  initial begin
    vec_t tv[$];
    int   sc;
    int   lat;
    logic [10:0] bits;
    logic [7:0]  b2b [8];
    int   gap;
    bit   stp, pok;
    real  ep;

    b2b = '{8'h55, 8'hA5, 8'h00, 8'h00, 8'h01, 8'hF4, 8'h03, 8'hF0};

    tv.push_back('{8'hA5, 1'b1, 1'b1,  0.0, 1'b0, 8'hA5});
    tv.push_back('{8'h3C, 1'b0, 1'b1,  0.0, 1'b1, 8'hA5});
    tv.push_back('{8'hF0, 1'b1, 1'b1,  0.0, 1'b0, 8'hF0});
    tv.push_back('{8'h00, 1'b1, 1'b1,  2.0, 1'b0, 8'h00});
    tv.push_back('{8'hFF, 1'b1, 1'b1, -2.0, 1'b0, 8'hFF});
    tv.push_back('{8'h81, 1'b0, 1'b1, -1.5, 1'b1, 8'hFF});
    tv.push_back('{8'h6B, 1'b1, 1'b1,  1.5, 1'b0, 8'h6B});
`ifdef UART_RX_PARITY_EN
    tv.push_back('{8'h07, 1'b1, 1'b0,  0.0, 1'b1, 8'h6B});
    tv.push_back('{8'h07, 1'b1, 1'b1,  0.0, 1'b0, 8'h07});
`endif

    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_done", rx_done, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    send(8'h55, 1'b1, 1'b1, 0.0, 20, sc);
    lat = (obs_q.size() > 0) ? obs_q[0].cyc - sc : -1;
    check("first_latency", lat, LATENCY);
    drain();
    check("first_rx_data", rx_data, 8'h55);

    // Glitch shorter than the start of the sample window.
    uart_rx = 1'b0;
    repeat (15) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    check("glitch_no_pulse", obs_q.size(), 0);

    for (int i = 0; i < tv.size(); i++) begin
      send(tv[i].data, tv[i].stop, tv[i].par_ok, tv[i].err_pct, 20, sc);
      repeat (20) @(posedge clk);
      #1;
      check("vec_pulse_count", obs_q.size(), 1);
      if (obs_q.size() > 0) check("vec_pulse_err", obs_q[0].err, tv[i].exp_err);
      drain();
      check("vec_rx_data", rx_data, tv[i].exp_rx);
    end

    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) send(b2b[i], 1'b1, 1'b1, pass == 0 ? 2.0 : -2.0, 0, sc);
      repeat (20) @(posedge clk);
      #1;
      check("b2b_count", obs_q.size(), 8);
      for (int i = 0; i < 8 && i < obs_q.size(); i++) check("b2b_byte", obs_q[i].data, b2b[i]);
      drain();
    end

    // Reset during data bit 4; held until the line is idle again.
    bits = {1'b1, 1'b1, 8'h5A, 1'b0};
    drive_frame(bits, 0.0, 5, sc);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_pulse", obs_q.size(), 0);
    check("abort_rx_data", rx_data, 8'h00);
    model_last = 8'h00;
    send(8'h81, 1'b1, 1'b1, 0.0, 20, sc);
    drain();
    check("after_reset_rx_data", rx_data, 8'h81);

    for (int i = 0; i < 16; i++) begin
      stp = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      pok = ($urandom_range(0, 5) != 0);
`else
      pok = 1'b1;
`endif
      ep  = (real'($urandom_range(0, 400)) - 200.0) / 100.0;
      gap = $urandom_range(0, 40);
      if (!stp && gap < 8) gap = 8;
      send(8'($urandom), stp, pok, ep, gap, sc);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
